// File: rtl/uart_pkg.sv
// Shared UART constants: bus widths, register offsets, register bit positions
// and the reset-time bit period helper.
package uart_pkg;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 32;

  localparam logic [ADDR_W-1:0] UART_RX_CTRL   = 4'h0;
  localparam logic [ADDR_W-1:0] UART_RX_BAUD   = 4'h4;
  localparam logic [ADDR_W-1:0] UART_RX_STATUS = 4'h8;
  localparam logic [ADDR_W-1:0] UART_RX_DATA   = 4'hC;

  // Word select, in the same order as the offsets above (addr[3:2]).
  typedef enum logic [1:0] {
    REG_CTRL   = 2'd0,
    REG_BAUD   = 2'd1,
    REG_STATUS = 2'd2,
    REG_DATA   = 2'd3
  } reg_sel_e;

  localparam int CTRL_RX_EN_BIT     = 0;
  localparam int CTRL_IRQ_EN_BIT    = 1;
  localparam int CTRL_FLUSH_BIT     = 2;

  localparam int STAT_NOT_EMPTY_BIT = 0;
  localparam int STAT_FULL_BIT      = 1;
  localparam int STAT_OVERRUN_BIT   = 2;
  localparam int STAT_COUNT_LSB     = 8;

  function automatic logic [15:0] default_bit_period(input int clk_freq, input int baud);
    return 16'(clk_freq / baud - 1);
  endfunction

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// Peripheral register bus between the bus decoder (master) and the UART RX
// controller (slave). One access per req_i cycle, acknowledged one cycle later.
interface uart_rx_ctrl_if;
  import uart_pkg::*;

  logic              req_i;
  logic              we_i;
  logic [ADDR_W-1:0] addr_i;
  logic [DATA_W-1:0] wdata_i;
  logic [DATA_W-1:0] rdata_o;
  logic              ack_o;

  modport master (
    output req_i, we_i, addr_i, wdata_i,
    input  rdata_o, ack_o
  );

  modport slave (
    input  req_i, we_i, addr_i, wdata_i,
    output rdata_o, ack_o
  );

endinterface

// File: rtl/sync_fifo.sv
// Synchronous FIFO with first-word-fall-through head. A push while full is
// accepted only if a pop happens in the same cycle; flush overrides both.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             push_en, pop_en;

  always_comb begin
    full    = (count_q == CNT_FULL);
    empty   = (count_q == '0);
    pop_en  = pop & ~flush & ~empty;
    push_en = push & ~flush & (~full | pop_en);

    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + (AW+1)'(push_en) - (AW+1)'(pop_en);
    if (push_en) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop_en) rd_ptr_d = rd_ptr_q + AW'(1);
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign dout  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/uart_rx_ctrl.sv
// Register-mapped controller for the UART receiver core: CTRL/BAUD/STATUS/DATA
// registers, rising-edge push of received bytes into an RX FIFO, and a level IRQ.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD_RATE  = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  uart_rx_ctrl_if.slave bus,
  output logic          rx_en_o,
  output logic          wr_bit_period_o,
  output logic [15:0]   bit_period_o,
  input  logic          rx_valid_i,
  input  logic [7:0]    rx_data_i,
  output logic          irq_o
);
  localparam int          CW     = $clog2(FIFO_DEPTH) + 1;
  localparam logic [15:0] BP_RST = default_bit_period(CLK_FREQ, BAUD_RATE);

  logic              rx_valid_q, rx_valid_d;
  logic              rx_en_q, rx_en_d;
  logic              irq_en_q, irq_en_d;
  logic              overrun_q, overrun_d;
  logic [15:0]       bit_period_q, bit_period_d;
  logic              wr_bp_q, wr_bp_d;
  logic              ack_q, ack_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              irq_q, irq_d;

  reg_sel_e          sel;
  logic              rd_acc, wr_acc;
  logic              push, pop, flush, ovr_set, ovr_clr;
  logic              fifo_full, fifo_empty;
  logic [CW-1:0]     fifo_count;
  logic [7:0]        fifo_head;
  logic [DATA_W-1:0] status_word;
  logic              unused_bus;

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .din   (rx_data_i),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    sel    = reg_sel_e'(bus.addr_i[3:2]);
    rd_acc = bus.req_i & ~bus.we_i;
    wr_acc = bus.req_i & bus.we_i;

    // Only a 0->1 edge of the held valid level pushes; the FIFO resolves pop-before-push.
    push    = rx_valid_i & ~rx_valid_q;
    pop     = rd_acc & (sel == REG_DATA) & ~fifo_empty;
    flush   = wr_acc & (sel == REG_CTRL) & bus.wdata_i[CTRL_FLUSH_BIT];
    ovr_set = push & fifo_full & ~pop & ~flush;
    ovr_clr = wr_acc & (sel == REG_STATUS) & bus.wdata_i[STAT_OVERRUN_BIT];

    status_word                                = '0;
    status_word[STAT_NOT_EMPTY_BIT]            = ~fifo_empty;
    status_word[STAT_FULL_BIT]                 = fifo_full;
    status_word[STAT_OVERRUN_BIT]              = overrun_q;
    status_word[STAT_COUNT_LSB +: 8]           = 8'(fifo_count);

    rx_valid_d   = rx_valid_i;
    rx_en_d      = rx_en_q;
    irq_en_d     = irq_en_q;
    bit_period_d = bit_period_q;
    wr_bp_d      = 1'b0;
    overrun_d    = ovr_set | (overrun_q & ~ovr_clr);
    ack_d        = bus.req_i;
    rdata_d      = '0;
    irq_d        = irq_en_q & (~fifo_empty | overrun_q);

    if (wr_acc) begin
      case (sel)
        REG_CTRL: begin
          rx_en_d  = bus.wdata_i[CTRL_RX_EN_BIT];
          irq_en_d = bus.wdata_i[CTRL_IRQ_EN_BIT];
        end
        REG_BAUD: begin
          bit_period_d = bus.wdata_i[15:0];
          wr_bp_d      = 1'b1;
        end
        default: ;
      endcase
    end

    if (rd_acc) begin
      case (sel)
        REG_CTRL: begin
          rdata_d[CTRL_RX_EN_BIT]  = rx_en_q;
          rdata_d[CTRL_IRQ_EN_BIT] = irq_en_q;
        end
        REG_BAUD:   rdata_d[15:0] = bit_period_q;
        REG_STATUS: rdata_d       = status_word;
        REG_DATA:   rdata_d[7:0]  = fifo_empty ? 8'h00 : fifo_head;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_valid_q   <= 1'b0;
      rx_en_q      <= 1'b0;
      irq_en_q     <= 1'b0;
      overrun_q    <= 1'b0;
      bit_period_q <= BP_RST;
      wr_bp_q      <= 1'b0;
      ack_q        <= 1'b0;
      rdata_q      <= '0;
      irq_q        <= 1'b0;
    end else begin
      rx_valid_q   <= rx_valid_d;
      rx_en_q      <= rx_en_d;
      irq_en_q     <= irq_en_d;
      overrun_q    <= overrun_d;
      bit_period_q <= bit_period_d;
      wr_bp_q      <= wr_bp_d;
      ack_q        <= ack_d;
      rdata_q      <= rdata_d;
      irq_q        <= irq_d;
    end
  end

  assign unused_bus      = ^{bus.addr_i[1:0], bus.wdata_i[DATA_W-1:16]};
  assign bus.ack_o       = ack_q;
  assign bus.rdata_o     = rdata_q;
  assign rx_en_o         = rx_en_q;
  assign wr_bit_period_o = wr_bp_q;
  assign bit_period_o    = bit_period_q;
  assign irq_o           = irq_q;

endmodule
